// File: rtl/uart_lb_pkg.sv
// uart_lb_pkg
//   Shared constants for the UART loopback engine: transform mode encodings
//   and default parameter values used by the top and the buffer sub-module.
package uart_lb_pkg;

    // Transform selected by the 'mode' input.
    localparam logic [1:0] MODE_PASS = 2'b00;  // forward unchanged
    localparam logic [1:0] MODE_ADD  = 2'b01;  // add STEP, wrapping
    localparam logic [1:0] MODE_INV  = 2'b10;  // bitwise invert
    localparam logic [1:0] MODE_REV  = 2'b11;  // bit-reverse

    // Default parameter values.
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_STEP   = 1;

endpackage

// File: rtl/lb_fifo.sv
// lb_fifo
//   Small synchronous FIFO holding transformed words between the RX pop and
//   the TX push. The head word is visible combinationally, so a word written
//   on one edge is available at the output in the very next cycle.
//
// Ports
//   clk, reset   : clock, asynchronous active-low reset
//   flush        : synchronous clear of pointers and level
//   push         : write push_data at the tail this edge
//   push_data    : word to write
//   pop          : retire the head word this edge
//   head         : current head word (meaningful when level > 0)
//   level        : occupancy, 0..DEPTH
module lb_fifo
    import uart_lb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      head,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push && (level_q < LW'(DEPTH)) && !flush;
    assign do_pop  = pop && (level_q != '0) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      level_d = level_q + LW'(1);
            else if (!do_push && do_pop) level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/uart_loopback_engine.sv
// uart_loopback_engine
//   Pops words from a UART RX FIFO, applies a selectable transform, buffers
//   them and pushes them to a UART TX FIFO. Forwarding is either continuous
//   (auto_en=1) or metered by step credits granted by step_tick pulses.
//
// Ports
//   clk, reset        : clock, asynchronous active-low reset
//   mode              : 00 PASS, 01 ADD(+STEP), 10 INV, 11 REV
//   auto_en           : 1 = forward freely, 0 = one pop per credit
//   step_tick         : one-cycle pulse granting one credit
//   flush             : synchronous clear of buffer and credits
//   rx_empty, r_data  : RX FIFO status and head word
//   rd_uart           : RX FIFO pop strobe
//   tx_full           : TX FIFO full flag
//   wr_uart, w_data   : TX FIFO push strobe and word
//   buf_level         : internal buffer occupancy
//   fwd_count         : running count of words pushed to TX (wraps)
module uart_loopback_engine
    import uart_lb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int STEP   = DEF_STEP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic                   auto_en,
    input  logic                   step_tick,
    input  logic                   flush,
    input  logic                   rx_empty,
    input  logic [DATA_W-1:0]      r_data,
    output logic                   rd_uart,
    input  logic                   tx_full,
    output logic                   wr_uart,
    output logic [DATA_W-1:0]      w_data,
    output logic [$clog2(DEPTH):0] buf_level,
    output logic [15:0]            fwd_count
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] xf_data;
    logic [DATA_W-1:0] head;
    logic [LW-1:0]     level;
    logic [LW-1:0]     credit_q, credit_d;
    logic [15:0]       fwd_q, fwd_d;
    logic              has_credit;

    lb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (rd_uart),
        .push_data (xf_data),
        .pop       (wr_uart),
        .head      (head),
        .level     (level)
    );

    assign has_credit = auto_en || (credit_q != '0);

    // Strobes are gated by reset directly so they drop the instant reset
    // asserts, independent of any registered state.
    assign rd_uart = reset && !rx_empty && (level < LW'(DEPTH)) && has_credit && !flush;
    assign wr_uart = reset && (level != '0) && !tx_full && !flush;
    assign w_data  = (reset && (level != '0)) ? head : '0;

    // Transform applied to the RX head at pop time; the buffered word keeps
    // whatever mode was active when it was popped.
    always_comb begin
        xf_data = r_data;
        case (mode)
            MODE_ADD: xf_data = r_data + DATA_W'(STEP);
            MODE_INV: xf_data = ~r_data;
            MODE_REV: begin
                for (int i = 0; i < DATA_W; i++) xf_data[i] = r_data[DATA_W-1-i];
            end
            default: xf_data = r_data;
        endcase
    end

    // Credits only matter in stepped mode; flush wins over a same-cycle tick.
    // A pop in stepped mode always has credit_q > 0, so the decrement is safe.
    always_comb begin
        credit_d = credit_q;
        if (flush || auto_en) begin
            credit_d = '0;
        end else if (step_tick && !rd_uart) begin
            if (credit_q < LW'(DEPTH)) credit_d = credit_q + LW'(1);
        end else if (!step_tick && rd_uart) begin
            credit_d = credit_q - LW'(1);
        end
    end

    always_comb begin
        fwd_d = fwd_q;
        if (wr_uart) fwd_d = fwd_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q <= '0;
            fwd_q    <= '0;
        end else begin
            credit_q <= credit_d;
            fwd_q    <= fwd_d;
        end
    end

    assign buf_level = level;
    assign fwd_count = fwd_q;

endmodule

// File: tb/tb_uart_loopback_engine.sv
// Directed bench for uart_loopback_engine (default parameters). The bench
// models the RX FIFO as a queue and logs every word pushed to TX.
module tb_uart_loopback_engine;
    import uart_lb_pkg::*;

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic       auto_en, step_tick, flush, rx_empty, tx_full;
    logic [7:0] r_data;
    logic       rd_uart, wr_uart;
    logic [7:0] w_data;
    logic [2:0] buf_level;
    logic [15:0] fwd_count;

    int total = 0;
    int bad   = 0;
    int pop_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];

    uart_loopback_engine dut (
        .clk(clk), .reset(reset), .mode(mode), .auto_en(auto_en),
        .step_tick(step_tick), .flush(flush), .rx_empty(rx_empty),
        .r_data(r_data), .rd_uart(rd_uart), .tx_full(tx_full),
        .wr_uart(wr_uart), .w_data(w_data), .buf_level(buf_level),
        .fwd_count(fwd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx();
        rx_empty = (rx_q.size() == 0);
        r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endtask

    function automatic logic [31:0] tx_at(input int i);
        return (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hDEAD;
    endfunction

    // One clock: sample strobes before the edge, update models after it,
    // settle new RX inputs at the following negedge.
    task automatic cyc();
        logic rd, wr;
        logic [7:0] wd;
        rd = rd_uart; wr = wr_uart; wd = w_data;
        @(posedge clk);
        if (rd && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            pop_cnt++;
        end
        if (wr) tx_log.push_back(wd);
        @(negedge clk);
        drive_rx();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic run_tx(input int want, input int budget);
        int n = 0;
        while (tx_log.size() < want && n < budget) begin
            cyc();
            n++;
        end
        chk("tx_count", tx_log.size(), want);
    endtask

    task automatic tick_pulse();
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b0; mode = MODE_ADD; auto_en = 1'b1; step_tick = 1'b0;
        flush = 1'b0; tx_full = 1'b0;
        rx_q = '{8'h41, 8'h42, 8'h43};
        drive_rx();
        #2;
        // Reset state, even with RX non-empty and auto forwarding enabled.
        chk("rst_rd_uart", rd_uart, 0);
        chk("rst_wr_uart", wr_uart, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_level", buf_level, 0);
        chk("rst_fwd", fwd_count, 0);

        @(negedge clk); #1;
        reset = 1'b1; #1;

        // Auto forwarding in ADD mode, one-cycle latency.
        chk("add_first_rd", rd_uart, 1);
        chk("add_first_wr", wr_uart, 0);
        cyc();
        chk("add_lat_wr", wr_uart, 1);
        chk("add_lat_data", w_data, 8'h42);
        chk("add_lat_level", buf_level, 1);
        run_tx(3, 20);
        chk("add_tx0", tx_at(0), 8'h42);
        chk("add_tx1", tx_at(1), 8'h43);
        chk("add_tx2", tx_at(2), 8'h44);
        chk("add_fwd", fwd_count, 3);

        // Transforms with per-word mode changes; earlier words keep their mode.
        rx_q = '{8'h01, 8'hA5, 8'hFF, 8'h3C};
        drive_rx(); #1;
        mode = MODE_REV;  cyc();
        mode = MODE_INV;  cyc();
        mode = MODE_ADD;  cyc();
        mode = MODE_PASS;
        run_tx(7, 20);
        chk("rev_01", tx_at(3), 8'h80);
        chk("inv_a5", tx_at(4), 8'h5A);
        chk("add_ff", tx_at(5), 8'h00);
        chk("pass_3c", tx_at(6), 8'h3C);
        chk("xf_fwd", fwd_count, 7);

        // Stepped mode: no pops without credit, then exactly three.
        auto_en = 1'b0;
        rx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        drive_rx(); #1;
        pop_cnt = 0;
        run(2);
        chk("step_idle_pops", pop_cnt, 0);
        chk("step_idle_rd", rd_uart, 0);
        step_tick = 1'b1;
        run(3);
        step_tick = 1'b0;
        run(6);
        chk("step_pops", pop_cnt, 3);
        chk("step_rx_left", rx_q.size(), 2);
        chk("step_tx_cnt", tx_log.size(), 10);
        chk("step_tx0", tx_at(7), 8'h10);
        chk("step_tx1", tx_at(8), 8'h11);
        chk("step_tx2", tx_at(9), 8'h12);
        chk("step_fwd", fwd_count, 10);
        chk("step_rd_end", rd_uart, 0);

        // Credit saturation at DEPTH: six ticks grant only four pops.
        rx_q.delete(); drive_rx(); #1;
        for (int i = 0; i < 6; i++) tick_pulse();
        rx_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        drive_rx(); #1;
        pop_cnt = 0;
        run(12);
        chk("sat_pops", pop_cnt, 4);
        chk("sat_rx_left", rx_q.size(), 2);
        chk("sat_tx0", tx_at(10), 8'h50);
        chk("sat_tx3", tx_at(13), 8'h53);
        chk("sat_fwd", fwd_count, 14);
        rx_q.delete(); drive_rx(); #1;

        // Backpressure: full buffer blocks pops, then drains in order.
        auto_en = 1'b1; tx_full = 1'b1;
        rx_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        drive_rx(); #1;
        pop_cnt = 0;
        run(8);
        chk("bp_pops", pop_cnt, 4);
        chk("bp_level", buf_level, 4);
        chk("bp_rd", rd_uart, 0);
        chk("bp_wr", wr_uart, 0);
        tx_full = 1'b0; #1;
        cyc();
        chk("bp_rel_level", buf_level, 3);
        chk("bp_both_rd", rd_uart, 1);
        chk("bp_both_wr", wr_uart, 1);
        cyc();
        chk("bp_same_level", buf_level, 3);
        run_tx(20, 20);
        for (int i = 0; i < 6; i++) chk($sformatf("bp_tx%0d", i), tx_at(14 + i), 8'h20 + i);
        chk("bp_fwd", fwd_count, 20);

        // Flush with three buffered words; tick in the same cycle is ignored.
        auto_en = 1'b0; tx_full = 1'b1; #1;
        for (int i = 0; i < 3; i++) tick_pulse();
        rx_q = '{8'h30, 8'h31, 8'h32};
        drive_rx(); #1;
        pop_cnt = 0;
        run(6);
        chk("fl_pops", pop_cnt, 3);
        chk("fl_level_pre", buf_level, 3);
        tx_full = 1'b0; flush = 1'b1; step_tick = 1'b1; #1;
        chk("fl_wr", wr_uart, 0);
        cyc();
        flush = 1'b0; step_tick = 1'b0; #1;
        chk("fl_level", buf_level, 0);
        chk("fl_wr_after", wr_uart, 0);
        chk("fl_fwd", fwd_count, 20);
        rx_q = '{8'h77}; drive_rx(); #1;
        pop_cnt = 0;
        run(3);
        chk("fl_no_credit", pop_cnt, 0);
        chk("fl_tx_cnt", tx_log.size(), 20);

        // Reset mid-transfer with two buffered words.
        rx_q.delete(); drive_rx();
        auto_en = 1'b1; tx_full = 1'b1;
        rx_q = '{8'h60, 8'h61}; drive_rx(); #1;
        run(4);
        chk("rs_level_pre", buf_level, 2);
        rx_q.push_back(8'h63); drive_rx(); #1;
        reset = 1'b0; tx_full = 1'b0; #1;
        chk("rs_rd", rd_uart, 0);
        chk("rs_wr", wr_uart, 0);
        chk("rs_w_data", w_data, 0);
        chk("rs_level", buf_level, 0);
        chk("rs_fwd", fwd_count, 0);
        cyc();
        rx_q.delete(); drive_rx();
        reset = 1'b1; #1;
        chk("rs_rel_level", buf_level, 0);
        chk("rs_rel_wr", wr_uart, 0);
        run(2);
        chk("rs_rel_fwd", fwd_count, 0);
        chk("rs_tx_cnt", tx_log.size(), 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
